if_id_buffer: RTL
=================

Name: if_id_buffer

Overview:
- Instruction fetch queue between the PC/IF stage and the ID stage.
- Captures {pc, inst, in_delay_slot} from IF each cycle IF presents a valid fetch, and presents the oldest entry to ID.
- Decouples fetch from ID stalls.
- Raises a stall request to the controller before it can overflow.
- Cleared by pipeline flush (exception/eret redirect).

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AFULL_LVL, 3, occupancy at or above which ibuf_stallreq_o asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid_i  in  1  IF presents a fetched instruction this cycle.
- if_pc_i  in  32  PC of the fetched instruction.
- if_inst_i  in  32  fetched instruction word.
- if_in_delay_slot_i  in  1  fetched instruction is a branch delay slot.
- flush_i  in  1  controller flush; discards all entries.
- id_stall_i  in  1  ID cannot accept an instruction this cycle.
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  32  head PC.
- id_inst_o  out  32  head instruction.
- id_in_delay_slot_o  out  1  head delay-slot flag.
- ibuf_stallreq_o  out  1  to controller; occupancy >= AFULL_LVL.
- ibuf_count_o  out  $clog2(DEPTH)+1  current occupancy.
- ibuf_overflow_o  out  1  sticky: a push was dropped because the queue was full.

Behaviour:
- Reset, asynchronous: all outputs are 0. Read/write pointers, count and overflow flag clear immediately on rst assertion, regardless of clk.
- Storage: circular array of DEPTH entries, each 65 bits ({in_delay_slot, pc, inst}).
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Count is tracked separately, giving DEPTH+1 distinguishable states.
- pop = id_valid_o & ~id_stall_i & ~flush_i.
- push = if_valid_i & ~flush_i & ((count < DEPTH) | pop).
  - When full, a simultaneous pop frees the slot, so the push is accepted.
- Count update: count_next = count + push - pop.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
- Latency: an entry pushed at edge N is visible on id_* after edge N, i.e. one cycle from IF presentation to ID.
- Head outputs are combinational reads of the entry at the read pointer, gated by count != 0.
- Empty behaviour:
  - id_valid_o = 0.
  - id_inst_o = 32'h0 (NOP), id_pc_o = 0, id_in_delay_slot_o = 0.
  - Pop never occurs when empty.
- Full with push and no pop:
  - The push is dropped; queue contents unchanged.
  - ibuf_overflow_o sets on the next edge and stays high until flush_i or rst.
  - In a correctly wired pipeline this never occurs; it exists as a verification check.
- ibuf_stallreq_o = (count >= AFULL_LVL), combinational from registered count.
  - AFULL_LVL = DEPTH-1 leaves one slot for the fetch already in flight when the controller stalls IF.
- Flush:
  - On the edge where flush_i = 1, both pointers and count go to 0 and ibuf_overflow_o clears.
  - Any push or pop that cycle is discarded.
  - flush_i has priority over every other event.
- Entry contents are not cleared by flush or reset; only validity is tracked via count.

Optional Feature:
- Macro: IBUF_BYPASS_EN.
- Defined: when count == 0, if_valid_i = 1 and flush_i = 0:
  - id_* are driven combinationally from the if_* inputs with id_valid_o = 1 (zero-latency pass-through).
  - If ~id_stall_i, the instruction is consumed and not written.
  - If id_stall_i, it is written as a normal push.
  - count, overflow and stallreq rules are otherwise unchanged.
- Not defined: strict one-cycle latency as above; empty queue always shows id_valid_o = 0.

Test Plan:
- Reset mid-operation: fill 2 entries, assert rst between edges -> id_valid_o, ibuf_count_o, ibuf_stallreq_o drop to 0 immediately; after release, first push of pc=32'hBFC00000 appears at id_pc_o one cycle later.
- Streaming: push pc 32'hBFC00000, +4, +8 on consecutive cycles with id_stall_i = 0 -> id_pc_o shows each one cycle later; count stays at 1; stallreq stays 0.
- Fill and backpressure: id_stall_i = 1, push 4 instructions -> count 1,2,3,4; stallreq rises when count reaches 3. Fifth push with no pop -> dropped, overflow = 1. Release stall -> entries drain in order with pc/inst/delay-slot intact.
- Full with simultaneous push/pop: count = 4, id_stall_i = 0, if_valid_i = 1 -> push accepted, count stays 4, overflow stays 0, new entry emerges after the 4 older ones.
- Flush priority: count = 3, assert flush_i with if_valid_i = 1 and id_stall_i = 0 -> next cycle count = 0, id_valid_o = 0, id_inst_o = 0, overflow cleared, flushed-cycle fetch absent.
- Delay-slot tag: push a branch (delay-slot 0) then its slot (delay-slot 1) across an ID stall -> id_in_delay_slot_o is 0 then 1, in order.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer: instruction fetch queue between the IF and ID stages.
//
// Entries of {in_delay_slot, pc, inst} are captured from IF whenever a fetch
// is presented and handed to ID in order, decoupling fetch from ID stalls.
// Occupancy is tracked in a separate counter so that all DEPTH+1 fill levels
// are distinguishable while the pointers simply wrap.
//
// Optional build macro IBUF_BYPASS_EN: when the queue is empty, a valid fetch
// is passed straight through to ID in the same cycle. It is written into the
// queue only if ID stalls.
module if_id_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_i,
  input  logic [31:0]              if_pc_i,
  input  logic [31:0]              if_inst_i,
  input  logic                     if_in_delay_slot_i,
  input  logic                     flush_i,
  input  logic                     id_stall_i,
  output logic                     id_valid_o,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_inst_o,
  output logic                     id_in_delay_slot_o,
  output logic                     ibuf_stallreq_o,
  output logic [$clog2(DEPTH):0]   ibuf_count_o,
  output logic                     ibuf_overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_LVL);

  // Entry layout: {in_delay_slot, pc[31:0], inst[31:0]}.
  logic [64:0]     mem_q [DEPTH];
  logic [64:0]     head;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            empty;
  logic            full;
  logic            bypass;
  logic            pop;
  logic            push;
  logic            q_push;
  logic            q_pop;
  logic            drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);
  assign head  = mem_q[rd_ptr_q];

`ifdef IBUF_BYPASS_EN
  // Empty queue with a live fetch: ID sees the fetch directly.
  assign bypass = empty & if_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Head presentation: stored entry if any, else bypassed fetch, else NOP.
  always_comb begin
    id_valid_o         = 1'b0;
    id_pc_o            = 32'h0;
    id_inst_o          = 32'h0;
    id_in_delay_slot_o = 1'b0;
    if (!empty) begin
      id_valid_o         = 1'b1;
      id_in_delay_slot_o = head[64];
      id_pc_o            = head[63:32];
      id_inst_o          = head[31:0];
    end else if (bypass) begin
      id_valid_o         = 1'b1;
      id_in_delay_slot_o = if_in_delay_slot_i;
      id_pc_o            = if_pc_i;
      id_inst_o          = if_inst_i;
    end
  end

  assign pop  = id_valid_o & ~id_stall_i & ~flush_i;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push = if_valid_i & ~flush_i & (~full | pop);
  // A bypassed fetch consumed by ID never touches storage.
  assign q_pop  = pop & ~empty;
  assign q_push = push & ~(bypass & ~id_stall_i);
  // Fetch lost because the queue was full and nothing drained.
  assign drop   = if_valid_i & ~flush_i & full & ~pop;

  assign ibuf_stallreq_o = (count_q >= AfullCnt);
  assign ibuf_count_o    = count_q;
  assign ibuf_overflow_o = overflow_q;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (q_push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (q_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({q_push, q_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state: cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage: no reset, validity lives entirely in count_q.
  always_ff @(posedge clk) begin
    if (q_push) begin
      mem_q[wr_ptr_q] <= {if_in_delay_slot_i, if_pc_i, if_inst_i};
    end
  end

endmodule
